// File: rtl/pin_cond_pkg.sv
// Shared constants for the pin conditioning stage that feeds the core's pin_in bus.
package pin_cond_pkg;

  localparam int PIN_W         = 32;
  localparam int SYNC_MIN      = 2;
  localparam int SYNC_MAX      = 4;
  localparam int FILT_BITS_DEF = 4;
  // Wide enough to count to SYNC_MAX + 1 startup edges.
  localparam int ARM_W         = $clog2(SYNC_MAX + 2);

  function automatic bit sync_len_ok(int n);
    return (n >= SYNC_MIN) && (n <= SYNC_MAX);
  endfunction

endpackage

// File: rtl/pin_filt.sv
// One pin: metastability synchronizer, optional glitch-reject filter and
// registered rise/fall event flags.
module pin_filt
  import pin_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_BITS   = FILT_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 pin_raw,
  input  logic                 filt_en,
  input  logic [FILT_BITS-1:0] filt_len,
  input  logic                 armed,
  output logic                 pin_in,
  output logic                 pin_rise,
  output logic                 pin_fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILT_BITS-1:0]   cnt_q, cnt_d;
  logic                   pin_q, pin_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_raw};
    pin_d  = pin_q;
    cnt_d  = '0;
    if (!filt_en) begin
      pin_d = s;
    end else if (s != pin_q) begin
      // >= (not ==) so a filt_len lowered below the running count commits at once.
      if (cnt_q >= filt_len) pin_d = s;
      else                   cnt_d = cnt_q + 1'b1;
    end
    rise_d = armed &  pin_d & ~pin_q;
    fall_d = armed & ~pin_d &  pin_q;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sync_q <= '0;
      cnt_q  <= '0;
      pin_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      pin_q  <= pin_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign pin_in   = pin_q;
  assign pin_rise = rise_q;
  assign pin_fall = fall_q;

endmodule

// File: rtl/pin_cond.sv
// Conditions WIDTH asynchronous pins into the clk domain; ready marks the end of
// the post-reset window during which edge flags are suppressed.
module pin_cond
  import pin_cond_pkg::*;
#(
  parameter int WIDTH       = PIN_W,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_BITS   = FILT_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic [WIDTH-1:0]     pin_raw,
  input  logic [WIDTH-1:0]     filt_en,
  input  logic [FILT_BITS-1:0] filt_len,
  output logic [WIDTH-1:0]     pin_in,
  output logic [WIDTH-1:0]     pin_rise,
  output logic [WIDTH-1:0]     pin_fall,
  output logic                 ready
);

  if (!sync_len_ok(SYNC_STAGES)) begin : g_bad_sync_stages
    $error("pin_cond: SYNC_STAGES must lie in %0d..%0d", SYNC_MIN, SYNC_MAX);
  end

  logic [ARM_W-1:0] arm_q, arm_d;
  logic             ready_q, ready_d;

  // Ready rises on the SYNC_STAGES+1'th edge after reset, once the chains hold real pin data.
  always_comb begin
    arm_d   = arm_q;
    ready_d = ready_q;
    if (!ready_q) begin
      if (arm_q == ARM_W'(SYNC_STAGES)) ready_d = 1'b1;
      else                              arm_d   = arm_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      arm_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      arm_q   <= arm_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    pin_filt #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_BITS  (FILT_BITS)
    ) u_filt (
      .clk     (clk),
      .res     (res),
      .pin_raw (pin_raw[i]),
      .filt_en (filt_en[i]),
      .filt_len(filt_len),
      .armed   (ready_q),
      .pin_in  (pin_in[i]),
      .pin_rise(pin_rise[i]),
      .pin_fall(pin_fall[i])
    );
  end

endmodule
